// File: rtl/ones_accumulator.sv
// ones_accumulator
//   Sums the per-word ones counts of a frame of 15-bit words. The upstream
//   15-input ones counter supplies one 4-bit count per word. When the last
//   word is accepted, the block compares the frame total with a threshold.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a frame (sampled only in IDLE)
//   frame_len  number of words in the frame (sampled with start)
//   threshold  compare value for the frame total (sampled with start)
//   in_valid   count carries a valid per-word ones count
//   count      ones count of one word, 0..15
//   in_ready   word accepted this cycle when in_valid is also high
//   busy       frame in progress (ACCUM or DONE)
//   done       one-cycle frame-complete pulse
//   total      accumulated ones of the current / last frame
//   above      total >= threshold for the last completed frame
module ones_accumulator #(
  parameter int LEN_W = 8,
  parameter int TOT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [TOT_W-1:0] threshold,
  input  logic             in_valid,
  input  logic [3:0]       count,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [TOT_W-1:0] total,
  output logic             above
);

  // A full frame of 15s must fit in total without wrapping.
  if (TOT_W < LEN_W + 4) begin : g_bad_width
    $error("ones_accumulator: TOT_W must be >= LEN_W + 4");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] remaining;
  logic [TOT_W-1:0] thr_q;
  logic             accept;
  logic             last_word;
  logic [TOT_W-1:0] total_sum;

  assign accept    = (state == ACCUM) && in_valid;
  assign last_word = accept && (remaining == LEN_W'(1));
  assign total_sum = total + TOT_W'(count);

  // NOTE: sequential state is assigned with <= so that every register
  // samples the values from before the edge, whatever the block order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next is given a default before the case, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (frame_len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (last_word) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      thr_q     <= '0;
      total     <= '0;
      above     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= frame_len;
            thr_q     <= threshold;
            total     <= '0;
            // An empty frame enters DONE on this same edge. Its compare is
            // 0 >= threshold, which is true only when threshold is zero.
            above     <= (frame_len == '0) && (threshold == '0);
          end
        end
        ACCUM: begin
          if (accept) begin
            total     <= total_sum;
            remaining <= remaining - LEN_W'(1);
            if (last_word) above <= (total_sum >= thr_q);
          end
        end
        default: ;
      endcase
    end
  end

  // All handshake and status outputs decode straight from the state register.
  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule

// File: doc/ones_accumulator.md
ONES_ACCUMULATOR -- requirements
Module: ones_accumulator

Interface
REQ-001 Parameter LEN_W, default 8: width of frame_len and of the internal remaining-word counter.
REQ-002 Parameter TOT_W, default 12: width of total and threshold; TOT_W SHALL be >= LEN_W+4.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a new frame; sampled only in IDLE.
REQ-006 frame_len  input  LEN_W  number of 15-bit words in the frame; sampled with start.
REQ-007 threshold  input  TOT_W  compare value; sampled with start.
REQ-008 in_valid  input  1  count holds a valid per-word ones count.
REQ-009 count  input  4  ones count of one 15-bit word (0..15) from the upstream 15-input ones counter; bit 0 = LSB.
REQ-010 in_ready  output  1  block accepts count this cycle.
REQ-011 busy  output  1  frame in progress (state ACCUM or DONE).
REQ-012 done  output  1  one-cycle frame-complete pulse.
REQ-013 total  output  TOT_W  accumulated ones of the current/last frame.
REQ-014 above  output  1  total >= threshold for the last completed frame.

Function
REQ-015 The block SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-016 IDLE: in_ready=0, busy=0; on start=1, latch frame_len into remaining, latch threshold, clear total to 0, clear above to 0.
REQ-017 IDLE with start=1 and frame_len=0 SHALL go to DONE (total stays 0); with frame_len>0 SHALL go to ACCUM.
REQ-018 ACCUM: in_ready=1; a word is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-019 On acceptance total SHALL increase by zero-extended count and remaining SHALL decrement by 1, both registered at that edge.
REQ-020 Cycles in ACCUM with in_valid=0 SHALL leave total and remaining unchanged (arbitrary gaps allowed).
REQ-021 Acceptance with remaining=1 SHALL transition to DONE; in_ready SHALL be 0 from the following cycle, so no word beyond frame_len is ever accepted.
REQ-022 On the edge entering DONE, above SHALL be registered as (final total >= latched threshold), unsigned compare.
REQ-023 DONE: done=1 for exactly one cycle, in_ready=0, busy=1; next state IDLE unconditionally.
REQ-024 Latency: done SHALL assert the cycle immediately after the last accepted word; after start with frame_len=0, the cycle after start.
REQ-025 total and above SHALL hold their values in IDLE after DONE until the next accepted start.
REQ-026 start asserted in ACCUM or DONE SHALL be ignored (no restart, no latching).
REQ-027 Width: maximum total = (2^LEN_W-1)*15, which fits TOT_W; no saturation or overflow logic needed.
REQ-028 count values are used as given; no range check (4 bits cannot exceed 15).
REQ-029 All outputs SHALL be registered or decoded directly from the registered state; no combinational path from inputs to outputs.

Reset
REQ-030 rst=1 at a rising edge SHALL force state IDLE, total=0, remaining=0, latched threshold=0, above=0, done=0, in_ready=0, busy=0.
REQ-031 rst SHALL take priority over start and in_valid in the same cycle.
REQ-032 rst mid-frame (ACCUM or DONE) SHALL abort the frame without a done pulse; the next start begins a clean frame.

Verification
REQ-033 Reset then start, frame_len=3, threshold=20, counts 15,0,7 with in_valid continuous -> done one cycle after third word, total=22, above=1.
REQ-034 frame_len=4, threshold=40, counts 15,15,15,15 with in_valid gaps of 2 cycles between words -> total=60, above=1, exactly 4 acceptances, in_ready=0 after the 4th.
REQ-035 start with frame_len=0, threshold=1 -> done the next cycle, total=0, above=0; in_ready never asserts.
REQ-036 frame_len=255, count=15 every cycle -> total=3825, done one cycle after 255th accept; extra in_valid after that not accepted.
REQ-037 frame_len=5, rst asserted after 2 accepted words -> no done pulse, total=0, state IDLE; restart frame_len=1, count=9, threshold=9 -> total=9, above=1.
REQ-038 start pulsed again during ACCUM with different frame_len/threshold -> ignored; original frame completes with original length and threshold.
